// File: rtl/riscv_pkg.sv
// Shared constants and types for the single-cycle RISC-V core.
// The fetch FSM state type lives here so debug tooling can decode dbg_state.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    VALID = 3'd2,
    DROP  = 3'd3,
    HALT  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/branch_target_adder.sv
// Combinational branch/jump target: base + imm, bit0 cleared for JALR.
// Flags targets that are not 4-byte aligned; shared with execute.
module branch_target_adder #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] base,
  input  logic [XLEN-1:0] imm,
  input  logic            jalr,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  logic [XLEN-1:0] sum;

  assign sum      = base + imm;
  assign target   = {sum[XLEN-1:1], sum[0] & ~jalr};
  assign misalign = (target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack and hands
// instructions to decode over valid/ready, applying branch/jump redirects.
module fetch_unit #(
  parameter int               XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_base,
  input  logic [XLEN-1:0] redirect_imm,
  input  logic            redirect_jalr,
  output logic            misalign,
  output logic [2:0]      dbg_state
);

  import riscv_pkg::*;

  // Handshakes: a memory transfer completes on a rising edge with
  // imem_req=1 and imem_ack=1; req/addr hold until then. A decode transfer
  // completes on a rising edge with instr_valid=1 and instr_ready=1;
  // instr/instr_pc hold while valid is waiting.

  fetch_state_t    state, state_d;
  logic [XLEN-1:0] pc, pc_d;
  logic [XLEN-1:0] pending_target, pending_target_d;
  logic [31:0]     instr_d;
  logic [XLEN-1:0] instr_pc_d;
  logic            misalign_d;
  logic [XLEN-1:0] tgt;
  logic            tgt_misalign;

  branch_target_adder #(.XLEN(XLEN)) u_target (
    .base     (redirect_base),
    .imm      (redirect_imm),
    .jalr     (redirect_jalr),
    .target   (tgt),
    .misalign (tgt_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      pending_target <= RESET_PC;
      instr          <= NOP_INSTR;
      instr_pc       <= RESET_PC;
      misalign       <= 1'b0;
    end else begin
      state          <= state_d;
      pc             <= pc_d;
      pending_target <= pending_target_d;
      instr          <= instr_d;
      instr_pc       <= instr_pc_d;
      misalign       <= misalign_d;
    end
  end

  always_comb begin
    state_d          = state;
    pc_d             = pc;
    pending_target_d = pending_target;
    instr_d          = instr;
    instr_pc_d       = instr_pc;
    misalign_d       = misalign;
    if (redirect_valid && state != HALT) begin
      if (tgt_misalign) begin
        misalign_d = 1'b1;
        state_d    = HALT;
      end else if ((state == FETCH || state == DROP) && !imem_ack) begin
        // Request still outstanding: wait out the ack, then jump.
        pending_target_d = tgt;
        state_d          = DROP;
      end else begin
        pc_d    = tgt;
        state_d = FETCH;
      end
    end else begin
      unique case (state)
        IDLE:  state_d = FETCH;
        FETCH: if (imem_ack) begin
                 instr_d    = imem_rdata;
                 instr_pc_d = pc;
                 state_d    = VALID;
               end
        VALID: if (instr_ready) begin
                 pc_d    = pc + XLEN'(4);
                 state_d = FETCH;
               end
        DROP:  if (imem_ack) begin
                 pc_d    = pending_target;
                 state_d = FETCH;
               end
        HALT:  state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // DROP keeps presenting the abandoned address, which is still pc.
  assign imem_req    = (state == FETCH) || (state == DROP);
  assign imem_addr   = pc;
  assign instr_valid = (state == VALID);
  assign dbg_state   = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations, then randomized traffic checked against a program-flow model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_base;
  logic [31:0] redirect_imm;
  logic        redirect_jalr;
  logic        misalign;
  logic [2:0]  dbg_state;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_base  (redirect_base),
    .redirect_imm   (redirect_imm),
    .redirect_jalr  (redirect_jalr),
    .misalign       (misalign),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Memory image: a fixed function of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h0101_0101) ^ 32'h1357_9BDF;
  endfunction

  // ---------------- driver ----------------
  int          mem_lat  = 0;
  int          mem_cnt  = 0;
  bit          rand_lat = 0;
  bit          mon_en   = 0;
  logic        s_req, s_valid, s_misalign;
  logic [31:0] s_addr, s_pc, s_instr;

  // Runs one cycle starting at a falling edge: caller has set ready/redirect.
  task automatic step();
    #1;
    if (imem_req) begin
      if (mem_cnt >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = memf(imem_addr);
        mem_cnt    = 0;
        if (rand_lat) mem_lat = $urandom_range(0, 3);
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        mem_cnt++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      mem_cnt    = 0;
    end
    #1;
    s_req      = imem_req;
    s_addr     = imem_addr;
    s_valid    = instr_valid;
    s_pc       = instr_pc;
    s_instr    = instr;
    s_misalign = misalign;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"},      imem_req,    1'b0);
    chk({tag, "_addr"},     imem_addr,   RESET_PC);
    chk({tag, "_valid"},    instr_valid, 1'b0);
    chk({tag, "_instr"},    instr,       NOP_INSTR);
    chk({tag, "_pc"},       instr_pc,    RESET_PC);
    chk({tag, "_misalign"}, misalign,    1'b0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    imem_ack       = 1'b0;
    mem_cnt        = 0;
    #1;
    check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] base, input logic [31:0] imm, input logic jalr);
    redirect_valid = 1'b1;
    redirect_base  = base;
    redirect_imm   = imm;
    redirect_jalr  = jalr;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [31:0] exp_q[$];
  bit          halted;
  logic        p_req, p_ack, p_valid, p_ready, p_redir;
  logic [31:0] p_addr, p_instr, p_pc;
  int          idle_cnt;

  initial begin
    logic [31:0] t;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (!mon_en) begin
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        halted   = 0;
        idle_cnt = 0;
        p_req = 0; p_ack = 0; p_valid = 0; p_ready = 0; p_redir = 0;
        p_addr = '0; p_instr = '0; p_pc = '0;
      end else begin
        if (halted) begin
          chk("halt_req",      imem_req,    1'b0);
          chk("halt_valid",    instr_valid, 1'b0);
          chk("halt_misalign", misalign,    1'b1);
        end else begin
          chk("misalign_clear", misalign, 1'b0);
          if (p_req && !p_ack) begin
            chk("req_hold",  imem_req,  1'b1);
            chk("addr_hold", imem_addr, p_addr);
          end
          if (p_valid && !p_ready && !p_redir) begin
            chk("valid_hold", instr_valid, 1'b1);
            chk("instr_hold", instr,       p_instr);
            chk("pc_hold",    instr_pc,    p_pc);
          end
          if (imem_req) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
          if (instr_valid) begin
            chk("instr_pc_flow", instr_pc, exp_q.size() > 0 ? exp_q[0] : 32'hDEAD_BEEF);
            chk("instr_data",    instr,    memf(instr_pc));
          end
          if (instr_valid && instr_ready) begin
            idle_cnt = 0;
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              if (!redirect_valid) exp_q.push_back(e + 32'd4);
            end
          end else begin
            idle_cnt++;
          end
          if (redirect_valid) begin
            t = redirect_base + redirect_imm;
            if (redirect_jalr) t[0] = 1'b0;
            if (t[1:0] != 2'b00) begin
              halted = 1;
            end else begin
              exp_q.delete();
              exp_q.push_back(t);
              idle_cnt = 0;
            end
          end
          if (idle_cnt > 200) begin
            timeout_fail("progress");
            idle_cnt = 0;
          end
        end
        p_req   = imem_req;
        p_ack   = imem_ack;
        p_addr  = imem_addr;
        p_valid = instr_valid;
        p_ready = instr_ready;
        p_redir = redirect_valid;
        p_instr = instr;
        p_pc    = instr_pc;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    bit seen14;
    rst_n          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_base  = '0;
    redirect_imm   = '0;
    redirect_jalr  = 1'b0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;

    // T1: zero-wait memory, decode always ready.
    do_reset();
    mem_lat = 0; rand_lat = 0;
    for (int c = 0; c < 7; c++) begin
      instr_ready = 1'b1;
      step();
      chk($sformatf("t1_req_c%0d", c),   s_req,   1'((c % 2) == 1));
      chk($sformatf("t1_valid_c%0d", c), s_valid, 1'((c % 2) == 0 && c > 0));
      if (c % 2 == 1) chk($sformatf("t1_addr_c%0d", c), s_addr, 32'((c - 1) * 2));
      if (c % 2 == 0 && c > 0) chk($sformatf("t1_pc_c%0d", c), s_pc, 32'((c - 2) * 2));
    end

    // T2: slow memory and stalled decode.
    do_reset();
    mem_lat = 3; instr_ready = 1'b0;
    step();
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("t2_req_held",  s_req,   1'b1);
      chk("t2_addr_held", s_addr,  32'h0);
      chk("t2_no_valid",  s_valid, 1'b0);
    end
    for (int c = 5; c <= 8; c++) begin
      step();
      chk("t2_valid",   s_valid, 1'b1);
      chk("t2_pc",      s_pc,    32'h0);
      chk("t2_instr",   s_instr, 32'h1357_9BDF);
      chk("t2_no_req",  s_req,   1'b0);
    end
    instr_ready = 1'b1;
    step();
    chk("t2_valid_hs", s_valid, 1'b1);
    step();
    chk("t2_next_req",  s_req,  1'b1);
    chk("t2_next_addr", s_addr, 32'h4);

    // T3: branch taken while instruction at 0x10 is presented.
    do_reset();
    mem_lat = 0; instr_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (s_req && s_addr == 32'h10) found = 1;
    end
    if (!found) timeout_fail("t3_reach_0x10");
    redirect(32'h10, 32'h0000_0614, 1'b0);
    step();
    chk("t3_valid_0x10", s_pc, 32'h10);
    step();
    chk("t3_req",    s_req,  1'b1);
    chk("t3_target", s_addr, 32'h624);
    seen14 = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_valid && s_pc == 32'h14) seen14 = 1;
    end
    chk("t3_0x14_skipped", seen14, 1'b0);

    // T4: two redirects while a request is outstanding.
    do_reset();
    mem_lat = 3; instr_ready = 1'b1;
    step();
    redirect(32'h0, 32'h100, 1'b0);
    step();
    chk("t4_req_c1", s_addr, 32'h0);
    redirect(32'h40, 32'hFFFF_FFF0, 1'b0);
    step();
    chk("t4_drop_req",  s_req,   1'b1);
    chk("t4_drop_addr", s_addr,  32'h0);
    chk("t4_drop_nv",   s_valid, 1'b0);
    step();
    step();
    chk("t4_stale_nv", s_valid, 1'b0);
    step();
    chk("t4_new_req",  s_req,  1'b1);
    chk("t4_new_addr", s_addr, 32'h30);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (s_valid) begin
        found = 1;
        chk("t4_pc",    s_pc,    32'h30);
        chk("t4_instr", s_instr, 32'h2367_ABEF);
      end
    end
    if (!found) timeout_fail("t4_wait_valid");

    // T5: JALR clears bit0, then a misaligned branch halts fetch.
    do_reset();
    mem_lat = 0; instr_ready = 1'b1;
    step();
    redirect(32'h101, 32'h4, 1'b1);
    step();
    redirect(32'h100, 32'h2, 1'b0);
    step();
    chk("t5_jalr_addr", s_addr,     32'h104);
    chk("t5_no_mis",    s_misalign, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_misalign", s_misalign, 1'b1);
      chk("t5_halt_req", s_req,      1'b0);
      chk("t5_halt_nv",  s_valid,    1'b0);
    end

    // T6: asynchronous reset in the middle of a pending fetch.
    do_reset();
    mem_lat = 0; instr_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (s_valid && s_pc == 32'h4) found = 1;
    end
    if (!found) timeout_fail("t6_reach_0x4");
    mem_lat = 10;
    step();
    chk("t6_req_pending", s_req,  1'b1);
    chk("t6_addr_8",      s_addr, 32'h8);
    mon_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("t6_async");
    mem_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; mon_en = 1'b1; mem_lat = 0;
    step();
    step();
    chk("t6_restart_req",  s_req,  1'b1);
    chk("t6_restart_addr", s_addr, RESET_PC);

    // Randomized traffic against the program-flow model.
    do_reset();
    rand_lat = 1; mem_lat = $urandom_range(0, 3);
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 7) == 0) begin
          redirect(32'hFFFF_FFFC, 32'h0, 1'b0);
        end else if ($urandom_range(0, 1) == 1) begin
          redirect(($urandom & 32'hFFFF_FFFC) | 32'h1, $urandom & 32'hFFFF_FFFC, 1'b1);
        end else begin
          redirect($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, 1'b0);
        end
      end
      step();
    end
    redirect($urandom & 32'hFFFF_FFFC, 32'h2, 1'b0);
    step();
    for (int i = 0; i < 20; i++) begin
      instr_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    chk("final_misalign", s_misalign, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
